// File: rtl/page_table_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : page_table_walker                                            |
// | Description : Hardware TLB refill engine. Serves data/instruction TLB      |
// |               misses (data first) by reading a 32-bit PTE from a single-   |
// |               level page table based at CP0 register CP0_PT_ADDR, then     |
// |               either refills the requesting TLB or raises a page fault.    |
// |               Optional feature macro: PTW_ACCESS_CHECK_EN (store to a      |
// |               read-only page faults with code 2'b10).                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module page_table_walker #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CP0_REASON_ADDR = 10,
  parameter int CP0_PT_ADDR     = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_req,
  input  logic [19:0]           i_miss_vpn,
  output logic                  i_miss_ack,
  input  logic                  d_miss_req,
  input  logic [19:0]           d_miss_vpn,
  input  logic                  d_miss_write,
  output logic                  d_miss_ack,
  output logic                  refill_valid,
  output logic                  refill_sel,
  output logic [4:0]            refill_index,
  output logic [63:0]           refill_entry,
  output logic [4:0]            cp0_addr_r,
  input  logic [ADDR_WIDTH-1:0] cp0_data_r,
  output logic                  cp0_we,
  output logic [4:0]            cp0_addr_w,
  output logic [31:0]           cp0_data_w,
  output logic                  pf_exception,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ready_i
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [4:0] C_PT_REG     = CP0_PT_ADDR[4:0];
  localparam logic [4:0] C_REASON_REG = CP0_REASON_ADDR[4:0];

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_sel;
  logic [19:0]           r_vpn;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_pte;
  logic [1:0]            r_code;
  logic [4:0]            r_icnt;
  logic [4:0]            r_dcnt;
  logic [19:0]           w_vpn;
  logic                  w_fault;
  logic [1:0]            w_code;

  // Data side wins when both TLBs miss in the same cycle.
  assign w_vpn = d_miss_req ? d_miss_vpn : i_miss_vpn;

`ifdef PTW_ACCESS_CHECK_EN
  logic r_write;
  // Invalid PTE takes precedence over the write-permission fault.
  assign w_fault = ~mem_data_i[0] | (r_sel & r_write & ~mem_data_i[1]);
  assign w_code  = ~mem_data_i[0] ? 2'b01 : 2'b10;
`else
  logic w_unused_write;
  assign w_unused_write = d_miss_write;
  assign w_fault = ~mem_data_i[0];
  assign w_code  = 2'b01;
`endif

  // State register; reset abandons any walk in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (d_miss_req || i_miss_req) w_next_state = S_FETCH;
      S_FETCH:  if (mem_ready_i) w_next_state = w_fault ? S_FAULT : S_REFILL;
      S_REFILL: w_next_state = S_IDLE;
      S_FAULT:  w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Request capture, PTE capture and per-TLB replacement counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel  <= 1'b0;
      r_vpn  <= '0;
      r_addr <= '0;
      r_pte  <= '0;
      r_code <= 2'b00;
      r_icnt <= 5'd1;
      r_dcnt <= 5'd1;
`ifdef PTW_ACCESS_CHECK_EN
      r_write <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (d_miss_req || i_miss_req) begin
            r_sel  <= d_miss_req;
            r_vpn  <= w_vpn;
            // Base is sampled only here; carry out of the add is dropped.
            r_addr <= cp0_data_r + {{(ADDR_WIDTH-22){1'b0}}, w_vpn, 2'b00};
`ifdef PTW_ACCESS_CHECK_EN
            r_write <= d_miss_req & d_miss_write;
`endif
          end
        end
        S_FETCH: begin
          if (mem_ready_i) begin
            r_pte  <= mem_data_i;
            r_code <= w_code;
          end
        end
        S_REFILL: begin
          // Slot 0 is reserved, so counters run 1..31 and wrap back to 1.
          if (r_sel) r_dcnt <= (r_dcnt == 5'd31) ? 5'd1 : r_dcnt + 5'd1;
          else       r_icnt <= (r_icnt == 5'd31) ? 5'd1 : r_icnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign cp0_addr_r = C_PT_REG;
  assign cp0_addr_w = C_REASON_REG;

  // State-decoded outputs; everything idles at zero outside its own state.
  always_comb begin
    i_miss_ack   = 1'b0;
    d_miss_ack   = 1'b0;
    refill_valid = 1'b0;
    refill_sel   = 1'b0;
    refill_index = 5'd0;
    refill_entry = 64'd0;
    cp0_we       = 1'b0;
    cp0_data_w   = 32'd0;
    pf_exception = 1'b0;
    mem_rd_o     = 1'b0;
    mem_addr_o   = '0;
    case (r_state)
      S_FETCH: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = r_addr;
      end
      S_REFILL: begin
        refill_valid = 1'b1;
        refill_sel   = r_sel;
        refill_index = r_sel ? r_dcnt : r_icnt;
        refill_entry = {r_vpn, 12'd0, r_pte};
        d_miss_ack   = r_sel;
        i_miss_ack   = ~r_sel;
      end
      S_FAULT: begin
        cp0_we       = 1'b1;
        pf_exception = 1'b1;
        cp0_data_w   = {r_vpn, 10'd0, r_code};
        d_miss_ack   = r_sel;
        i_miss_ack   = ~r_sel;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_page_table_walker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_page_table_walker                                         |
// | Description : Directed self-checking bench for page_table_walker.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_page_table_walker;

  logic        clk;
  logic        rst;
  logic        i_miss_req;
  logic [19:0] i_miss_vpn;
  logic        i_miss_ack;
  logic        d_miss_req;
  logic [19:0] d_miss_vpn;
  logic        d_miss_write;
  logic        d_miss_ack;
  logic        refill_valid;
  logic        refill_sel;
  logic [4:0]  refill_index;
  logic [63:0] refill_entry;
  logic [4:0]  cp0_addr_r;
  logic [31:0] cp0_data_r;
  logic        cp0_we;
  logic [4:0]  cp0_addr_w;
  logic [31:0] cp0_data_w;
  logic        pf_exception;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] mem_data_i;
  logic        mem_ready_i;

  int checks;
  int errors;

  page_table_walker dut (
    .clk          (clk),
    .rst          (rst),
    .i_miss_req   (i_miss_req),
    .i_miss_vpn   (i_miss_vpn),
    .i_miss_ack   (i_miss_ack),
    .d_miss_req   (d_miss_req),
    .d_miss_vpn   (d_miss_vpn),
    .d_miss_write (d_miss_write),
    .d_miss_ack   (d_miss_ack),
    .refill_valid (refill_valid),
    .refill_sel   (refill_sel),
    .refill_index (refill_index),
    .refill_entry (refill_entry),
    .cp0_addr_r   (cp0_addr_r),
    .cp0_data_r   (cp0_data_r),
    .cp0_we       (cp0_we),
    .cp0_addr_w   (cp0_addr_w),
    .cp0_data_w   (cp0_data_w),
    .pf_exception (pf_exception),
    .mem_addr_o   (mem_addr_o),
    .mem_rd_o     (mem_rd_o),
    .mem_data_i   (mem_data_i),
    .mem_ready_i  (mem_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise a miss, serve the PTE after 'stall' wait cycles, and stop in the
  // cycle where the refill/fault outputs are expected.
  task automatic do_miss(input logic is_d, input logic [19:0] vpn, input logic wr,
                         input logic [31:0] pte, input int stall);
    logic [31:0] exp_addr;
    exp_addr = cp0_data_r + {10'd0, vpn, 2'b00};
    if (is_d) begin
      d_miss_req = 1'b1; d_miss_vpn = vpn; d_miss_write = wr;
    end else begin
      i_miss_req = 1'b1; i_miss_vpn = vpn;
    end
    @(posedge clk); #1;
    check("fetch_rd", {63'd0, mem_rd_o}, 64'd1);
    check("fetch_addr", {32'd0, mem_addr_o}, {32'd0, exp_addr});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_rd", {63'd0, mem_rd_o}, 64'd1);
      check("stall_addr", {32'd0, mem_addr_o}, {32'd0, exp_addr});
    end
    mem_data_i = pte; mem_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_data_i = 32'd0; mem_ready_i = 1'b0;
    if (is_d) begin d_miss_req = 1'b0; d_miss_write = 1'b0; end
    else i_miss_req = 1'b0;
  endtask

  task automatic check_refill(input string tag, input logic sel, input logic [4:0] idx,
                              input logic [63:0] entry);
    check({tag, "_valid"}, {63'd0, refill_valid}, 64'd1);
    check({tag, "_sel"}, {63'd0, refill_sel}, {63'd0, sel});
    check({tag, "_index"}, {59'd0, refill_index}, {59'd0, idx});
    check({tag, "_entry"}, refill_entry, entry);
    check({tag, "_ack"}, {62'd0, d_miss_ack, i_miss_ack}, sel ? 64'd2 : 64'd1);
    check({tag, "_nofault"}, {62'd0, pf_exception, cp0_we}, 64'd0);
  endtask

  task automatic step_idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_quiet"}, {60'd0, refill_valid, pf_exception, d_miss_ack, i_miss_ack}, 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    i_miss_req = 1'b0; i_miss_vpn = '0;
    d_miss_req = 1'b0; d_miss_vpn = '0; d_miss_write = 1'b0;
    cp0_data_r = 32'h0010_0000;
    mem_data_i = '0; mem_ready_i = 1'b0;

    // Reset values
    repeat (2) @(posedge clk); #1;
    check("rst_addr_r", {59'd0, cp0_addr_r}, 64'd11);
    check("rst_addr_w", {59'd0, cp0_addr_w}, 64'd10);
    check("rst_outs", {55'd0, mem_rd_o, refill_valid, refill_sel, cp0_we, pf_exception,
                       d_miss_ack, i_miss_ack, 2'b00}, 64'd0);
    check("rst_wide", {27'd0, refill_index, mem_addr_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Data refill
    do_miss(1'b1, 20'h00003, 1'b0, 32'hABCD_E003, 0);
    check_refill("drefill", 1'b1, 5'd1, 64'h00003000_ABCDE003);
    step_idle("drefill_end");

    // Instruction fault
    do_miss(1'b0, 20'hFFFFF, 1'b0, 32'h0000_0000, 0);
    check("fault_we", {63'd0, cp0_we}, 64'd1);
    check("fault_pf", {63'd0, pf_exception}, 64'd1);
    check("fault_data", {32'd0, cp0_data_w}, 64'hFFFF_F001);
    check("fault_norefill", {63'd0, refill_valid}, 64'd0);
    check("fault_ack", {62'd0, d_miss_ack, i_miss_ack}, 64'd1);
    step_idle("fault_end");

    // Priority: both requests in the same cycle
    i_miss_req = 1'b1; i_miss_vpn = 20'h00020;
    do_miss(1'b1, 20'h00010, 1'b0, 32'h1111_1001, 0);
    check_refill("prio_d", 1'b1, 5'd2, 64'h00010000_11111001);
    step_idle("prio_gap");
    do_miss(1'b0, 20'h00020, 1'b0, 32'h2222_2001, 0);
    check_refill("prio_i", 1'b0, 5'd1, 64'h00020000_22222001);
    step_idle("prio_end");

    // Instruction counter wrap: slots 2..31 then back to 1
    for (int k = 0; k < 31; k++) begin
      do_miss(1'b0, 20'h00100 + 20'(k), 1'b0, 32'h0000_5001, 0);
      check("wrap_index", {59'd0, refill_index}, (k < 30) ? 64'(k + 2) : 64'd1);
      step_idle("wrap_end");
    end
    do_miss(1'b1, 20'h00200, 1'b0, 32'h0000_6001, 0);
    check_refill("wrap_d", 1'b1, 5'd3, 64'h00200000_00006001);
    step_idle("wrap_d_end");

    // Memory stall of 5 cycles, new base taken at the next walk
    cp0_data_r = 32'hFFFF_FFF0;
    do_miss(1'b1, 20'h00008, 1'b0, 32'h0000_7001, 5);
    check_refill("stall", 1'b1, 5'd4, 64'h00008000_00007001);
    step_idle("stall_end");

    // Reset in the middle of a fetch
    cp0_data_r = 32'h0010_0000;
    i_miss_req = 1'b1; i_miss_vpn = 20'h00055;
    @(posedge clk); #1;
    check("midrst_fetch", {63'd0, mem_rd_o}, 64'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_rd", {63'd0, mem_rd_o}, 64'd0);
    check("midrst_addr", {32'd0, mem_addr_o}, 64'd0);
    i_miss_req = 1'b0;
    @(posedge clk); #1;
    check("midrst_quiet", {60'd0, refill_valid, pf_exception, d_miss_ack, i_miss_ack}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    do_miss(1'b1, 20'h00001, 1'b0, 32'h0000_8001, 0);
    check_refill("postrst_d", 1'b1, 5'd1, 64'h00001000_00008001);
    step_idle("postrst_d_end");
    do_miss(1'b0, 20'h00002, 1'b0, 32'h0000_9001, 0);
    check_refill("postrst_i", 1'b0, 5'd1, 64'h00002000_00009001);
    step_idle("postrst_i_end");

    // Store miss to a read-only page
    do_miss(1'b1, 20'h00044, 1'b1, 32'h1234_5001, 0);
`ifdef PTW_ACCESS_CHECK_EN
    check("acc_pf", {63'd0, pf_exception}, 64'd1);
    check("acc_data", {32'd0, cp0_data_w}, 64'h0004_4002);
    check("acc_norefill", {63'd0, refill_valid}, 64'd0);
`else
    check_refill("acc", 1'b1, 5'd2, 64'h00044000_12345001);
`endif
    step_idle("acc_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/page_table_walker.md
# page_table_walker

- Hardware TLB refill engine for the memory manage unit.
- Accepts instruction-side and data-side TLB miss requests and reads the 32-bit PTE from the single-level page table whose base is held in CP0 register `CP0_PT_ADDR`.
- On a valid PTE, returns a 64-bit TLB entry plus a replacement slot to the requesting TLB.
- On an invalid PTE, writes a reason word to CP0 and raises `pf_exception`.
- Sits between the MMU TLBs, CP0 and the data-side memory port.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data/PTE width
- `CP0_REASON_ADDR`, 10, CP0 register that receives the fault reason
- `CP0_PT_ADDR`, 11, CP0 register holding the page table base
- `clk` in 1: the block's one clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_miss_req` in 1: instruction TLB miss, level, held until ack
- `i_miss_vpn` in 20: faulting instruction VPN
- `i_miss_ack` out 1: one-cycle completion pulse (instruction)
- `d_miss_req` in 1: data TLB miss, level, held until ack
- `d_miss_vpn` in 20: faulting data VPN
- `d_miss_write` in 1: data miss caused by a store
- `d_miss_ack` out 1: one-cycle completion pulse (data)
- `refill_valid` out 1: one-cycle TLB write strobe
- `refill_sel` out 1: 0 = i_tlb, 1 = d_tlb
- `refill_index` out 5: TLB slot to write, range 1..31
- `refill_entry` out 64: {vpn[19:0], 12'b0, pte[31:0]}; bits [63:44] VPN, [31:12] PPN
- `cp0_addr_r` out 5: constant `CP0_PT_ADDR`
- `cp0_data_r` in 32: page table base
- `cp0_we` out 1: one-cycle CP0 write strobe
- `cp0_addr_w` out 5: constant `CP0_REASON_ADDR`
- `cp0_data_w` out 32: {vpn, 10'b0, code[1:0]}
- `pf_exception` out 1: one-cycle fault pulse
- `mem_addr_o` out 32: PTE address
- `mem_rd_o` out 1: read request, level
- `mem_data_i` in 32: PTE read data
- `mem_ready_i` in 1: read data valid

## Operation
- PTE format:
  - [31:12] PPN
  - [1] writable
  - [0] valid
  - other bits are carried into the entry unchanged.
- FSM has four states: IDLE, FETCH, REFILL, FAULT.
- IDLE:
  - If `d_miss_req`, latch the d VPN, `d_miss_write` and sel = 1.
  - Otherwise, if `i_miss_req`, latch the i VPN and sel = 0.
  - Data has fixed priority over instruction.
  - Latch the PTE address as `cp0_data_r` + {vpn, 2'b00}, modulo 2^32 (carry dropped).
  - Go to FETCH.
- FETCH:
  - Hold `mem_rd_o` = 1 and a stable `mem_addr_o`.
  - When `mem_ready_i` is high, latch `mem_data_i`.
  - Go to REFILL if the PTE is valid, otherwise go to FAULT.
- REFILL:
  - Assert `refill_valid`, `refill_sel`, `refill_index`, `refill_entry`, and the ack matching sel, all for exactly one cycle.
  - Advance that TLB's replacement counter.
  - Return to IDLE.
- FAULT:
  - Assert `cp0_we`, `pf_exception` and the ack matching sel for one cycle.
  - code = 2'b01 for an invalid PTE.
  - No refill is issued.
  - Return to IDLE.
- Replacement:
  - There are two independent 5-bit counters, one per TLB.
  - Each counter resets to 1 and increments after its own refill.
  - 31 wraps to 1; slot 0 is never written.
- Requesters must drop `req` in the cycle after `ack`. A req still high in IDLE is treated as a new miss.

## Timing
- Reset values:
  - All outputs 0, except `cp0_addr_r` = `CP0_PT_ADDR` and `cp0_addr_w` = `CP0_REASON_ADDR` (constants).
  - FSM in IDLE.
  - Both counters at 1.
- Reset asserted mid-walk:
  - The walk is abandoned immediately.
  - `mem_rd_o` drops asynchronously.
  - No ack, refill or fault is issued.
- Latency:
  - req seen in IDLE at edge N.
  - `mem_rd_o` high from cycle N+1.
  - `mem_ready_i` sampled at edge M.
  - refill/fault outputs and ack are valid in cycle M+1.
  - Minimum miss-to-ack is 3 cycles, with `mem_ready_i` already high at N+1.
- `mem_ready_i` is ignored outside FETCH.
- Both reqs high at once: data is served first; instruction is served in the next IDLE cycle.
- The PT base is sampled only in IDLE. A CP0 write during a walk affects only the next walk.

## Configuration
- `PTW_ACCESS_CHECK_EN` defined:
  - A data miss with `d_miss_write` = 1 and a valid PTE with writable = 0 goes to FAULT with code 2'b10.
  - Invalid PTEs still fault with code 2'b01; invalid takes precedence.
- `PTW_ACCESS_CHECK_EN` undefined: only the valid bit is checked, and the writable bit is ignored.

## Test plan
- Data refill:
  - Stimulus: base 0x0010_0000, `d_miss_vpn` 0x00003; `mem_addr_o` = 0x0010_000C; `mem_data_i` 0xABCDE003.
  - Response: `refill_entry` 0x00003000_ABCDE003, sel 1, index 1, `d_miss_ack` for one cycle.
- Fault:
  - Stimulus: `i_miss_vpn` 0xFFFFF; PTE 0x00000000.
  - Response: `cp0_we` with `cp0_data_w` 0xFFFFF001, `pf_exception` pulse, no `refill_valid`.
- Priority:
  - Stimulus: i and d requests raised in the same cycle.
  - Response: data is walked first; instruction is walked after `d_miss_ack`; each ack lasts one cycle.
- Counter wrap:
  - Stimulus: 32 instruction refills.
  - Response: indices 1..31, then 1; the d counter is unaffected.
- Memory stall and reset:
  - Stimulus: `mem_ready_i` held low for 5 cycles → expect `mem_rd_o` and `mem_addr_o` stable throughout. Assert `rst` low mid-FETCH → expect all outputs 0 immediately and the next miss indexed at slot 1.
- Access check (with `PTW_ACCESS_CHECK_EN`):
  - Stimulus: store miss, PTE 0x12345001.
  - Response: `cp0_data_w` low bits 2'b10 plus `pf_exception`.
  - Without the macro: refill succeeds.
